muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 131 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned multiply / restoring divide for the
// accumulator CPU. One step per clock, WIDTH steps per operation, results are
// registered and presented with one-cycle write strobes.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] br_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic [WIDTH-1:0] dr_out,
  output logic             wr_acc,
  output logic             wr_mr,
  output logic             wr_dr,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH:0]     sum;
  // Remainder is kept WIDTH wide between steps: it is always below the
  // divisor, so the extra bit only exists in the shifted trial value.
  logic [WIDTH-1:0]   rem, rem_nxt, quot, quot_nxt;
  logic [WIDTH:0]     rem_sh;
  logic               accept, div_zero, last;

  assign accept   = (state == IDLE) && start;
  assign div_zero = op && (br_in == '0);
  assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; divide by zero skips RUN entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? DONE : RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and strobe outputs decoded from state
  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    wr_acc = (state == DONE);
    wr_mr  = (state == DONE) && !op_q;
    wr_dr  = (state == DONE) &&  op_q;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};
    rem_sh   = {rem, quot[WIDTH-1]};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nxt  = WIDTH'(rem_sh - {1'b0, b_q});
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod    <= '0;
      rem     <= '0;
      quot    <= '0;
      acc_out <= '0;
      mr_out  <= '0;
      dr_out  <= '0;
      div0    <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      cnt  <= '0;
      a_q  <= acc_in;
      b_q  <= br_in;
      prod <= {{WIDTH{1'b0}}, br_in};
      rem  <= '0;
      quot <= acc_in;
      div0 <= div_zero;
      if (div_zero) begin
        acc_out <= '1;
        dr_out  <= acc_in;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (op_q) begin
        rem  <= rem_nxt;
        quot <= quot_nxt;
      end else begin
        prod <= prod_nxt;
      end
      if (last) begin
        if (op_q) begin
          acc_out <= quot_nxt;
          dr_out  <= rem_nxt;
        end else begin
          acc_out <= prod_nxt[WIDTH-1:0];
          mr_out  <= prod_nxt[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes the expected
// register-file view for every accepted operation, the monitor pops and
// compares whenever done is presented.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] acc_in, br_in;
  logic        busy, done, wr_acc, wr_mr, wr_dr, div0;
  logic [31:0] acc_out, mr_out, dr_out;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .acc_in(acc_in), .br_in(br_in),
    .busy(busy), .done(done),
    .acc_out(acc_out), .mr_out(mr_out), .dr_out(dr_out),
    .wr_acc(wr_acc), .wr_mr(wr_mr), .wr_dr(wr_dr), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] acc, mr, dr;
    logic        div0, wmr, wdr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, nops = 0, ndone = 0;
  logic [31:0] m_mr = '0, m_dr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every done against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("acc_out", acc_out, e.acc);
          chk("mr_out", mr_out, e.mr);
          chk("dr_out", dr_out, e.dr);
          chk("div0", div0, e.div0);
          chk("strobes", {wr_acc, wr_mr, wr_dr}, {1'b1, e.wmr, e.wdr});
          chk("busy_at_done", busy, 0);
        end
      end else begin
        chk("strobe_without_done", {wr_acc, wr_mr, wr_dr}, 0);
      end
    end
  end

  // Issue one operation, check latency/busy length; optionally pulse a
  // conflicting start at E10 which must be ignored.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit glitch);
    exp_t        e;
    logic [63:0] p;
    int          lat, bcnt;
    bit          seen, z;
    z = o && (b == 0);
    if (!o) begin
      p = 64'(a) * 64'(b);
      e = '{acc: p[31:0], mr: p[63:32], dr: m_dr, div0: 1'b0, wmr: 1'b1, wdr: 1'b0};
    end else if (z) begin
      e = '{acc: 32'hFFFF_FFFF, mr: m_mr, dr: a, div0: 1'b1, wmr: 1'b0, wdr: 1'b1};
    end else begin
      e = '{acc: a / b, mr: m_mr, dr: a % b, div0: 1'b0, wmr: 1'b0, wdr: 1'b1};
    end
    m_mr = e.mr;
    m_dr = e.dr;
    sb.push_back(e);
    nops++;
    @(negedge clk);
    start = 1'b1; op = o; acc_in = a; br_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); acc_in = $urandom; br_in = $urandom;
    lat = 0; bcnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1;
      if (glitch && lat == 10) begin
        start = 1'b1; op = ~o; acc_in = $urandom; br_in = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", lat, z ? 1 : 33);
    chk("busy_cycles", bcnt, z ? 0 : 32);
    @(negedge clk);
    chk("div0_held", div0, z);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        o;
    rst = 1'b1; start = 1'b0; op = 1'b0; acc_in = '0; br_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {acc_out, mr_out, dr_out}, 0);
    chk("rst_flags", {busy, done, wr_acc, wr_mr, wr_dr, div0}, 0);

    do_op(1'b0, 32'd7, 32'd6, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'd5, 32'd9, 0);
    do_op(1'b1, 32'd5, 32'd0, 0);
    do_op(1'b0, 32'd3, 32'd5, 0);
    do_op(1'b0, 32'd123, 32'd456, 1);
    do_op(1'b1, 32'hDEAD_BEEF, 32'd1000, 1);

    // Abort a multiply with reset sampled at E15
    @(negedge clk);
    start = 1'b1; op = 1'b0; acc_in = 32'h1234_5678; br_in = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {acc_out, mr_out, dr_out}, 0);
    chk("abort_flags", {busy, done, wr_acc, wr_mr, wr_dr, div0}, 0);
    m_mr = '0; m_dr = '0;
    repeat (3) @(negedge clk);
    do_op(1'b0, 32'd3, 32'd4, 0);

    for (int k = 0; k < 25; k++) begin
      o = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 16);
        default: b = $urandom;
      endcase
      do_op(o, a, b, bit'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", ndone, nops);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
